// File: rtl/dma_pkg.sv
// Shared encodings for the DMA transfer engine: op/type pairs, region bounds,
// instruction field positions, FSM states and the strobe payload.
package dma_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF    = 6;
  localparam int unsigned IO1_BASE_DEF = 192;
  localparam int unsigned IO2_BASE_DEF = 224;

  localparam int unsigned INSTR_W = 26;
  localparam int unsigned OP_HI   = 25;
  localparam int unsigned OP_LO   = 24;
  localparam int unsigned TYPE_HI = 23;
  localparam int unsigned TYPE_LO = 22;
  localparam int unsigned CNT_LO  = 0;

  // {op, type} as presented in instruction[25:22]
  typedef enum logic [3:0] {
    OP_IO2MEM  = 4'b0001,
    OP_MEM2IO  = 4'b0101,
    OP_MEM2MEM = 4'b0110
  } xfer_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One-hot region / write-strobe payload
  typedef struct packed {
    logic mem;
    logic io1;
    logic io2;
  } strobe_t;

  function automatic logic is_legal_xfer(input logic [3:0] xt);
    logic ok;
    ok = 1'b0;
    case (xt)
      OP_IO2MEM, OP_MEM2IO, OP_MEM2MEM: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dma_transfer_engine_if.sv
// Processor <-> DMA handoff and status bundle. The shared data bus stays a
// top-level inout so tristate resolution happens at one level of hierarchy.
interface dma_transfer_engine_if
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic               grant;
  logic [INSTR_W-1:0] DMA_instruction;
  logic [ADDR_W-1:0]  start_source;
  logic [ADDR_W-1:0]  start_destination;

  logic               busybus;
  logic [ADDR_W-1:0]  D_address;
  logic               D_IOWrite1;
  logic               D_IOWrite2;
  logic               D_memwrite;
  logic [CNT_W-1:0]   updated_count;
  logic [ADDR_W-1:0]  next_source;
  logic [ADDR_W-1:0]  next_destination;
  logic               done;
  logic               dma_error;

  modport master (
    output grant, DMA_instruction, start_source, start_destination,
    input  busybus, D_address, D_IOWrite1, D_IOWrite2, D_memwrite,
           updated_count, next_source, next_destination, done, dma_error
  );

  modport slave (
    input  grant, DMA_instruction, start_source, start_destination,
    output busybus, D_address, D_IOWrite1, D_IOWrite2, D_memwrite,
           updated_count, next_source, next_destination, done, dma_error
  );

endinterface

// File: rtl/dma_region_decode.sv
// Combinational address -> one-hot {mem, io1, io2} region decode.
module dma_region_decode
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned IO1_BASE = IO1_BASE_DEF,
  parameter int unsigned IO2_BASE = IO2_BASE_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output strobe_t           hot_c
);

  logic [31:0] addr_ext_c;

  assign addr_ext_c = 32'(addr);

  always_comb begin
    hot_c = '0;
    if (addr_ext_c >= IO2_BASE) begin
      hot_c.io2 = 1'b1;
    end else if (addr_ext_c >= IO1_BASE) begin
      hot_c.io1 = 1'b1;
    end else begin
      hot_c.mem = 1'b1;
    end
  end

endmodule

// File: rtl/dma_transfer_engine.sv
// DMA responder: accepts a granted transfer instruction and moves count words,
// one READ and one WRITE cycle per word. Optional region checking: DMA_REGION_CHECK_EN.
module dma_transfer_engine
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned IO1_BASE = IO1_BASE_DEF,
  parameter int unsigned IO2_BASE = IO2_BASE_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  inout  wire  [DATA_W-1:0]     databus,
  dma_transfer_engine_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               drive_q, drive_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  strobe_t            strb_q, strb_d;
  logic [CNT_W-1:0]   ucnt_q, ucnt_d;
  logic [ADDR_W-1:0]  nsrc_q, nsrc_d;
  logic [ADDR_W-1:0]  ndst_q, ndst_d;
  logic               done_q, done_d;

  logic [1:0]         op_c;
  logic [1:0]         type_c;
  logic [CNT_W-1:0]   cnt_in_c;
  logic               legal_c;
  logic               known_c;
  logic               accept_c;
  logic               acc_region_ok_c;
  logic               step_ok_c;
  logic               unused_instr_c;
  strobe_t            dst_hot_c;

  assign op_c           = bus.DMA_instruction[OP_HI:OP_LO];
  assign type_c         = bus.DMA_instruction[TYPE_HI:TYPE_LO];
  assign cnt_in_c       = bus.DMA_instruction[CNT_LO +: CNT_W];
  assign unused_instr_c = ^bus.DMA_instruction[TYPE_LO-1:CNT_LO+CNT_W];

  // An instruction with any X/Z in op/type/count is never accepted
  assign known_c  = !$isunknown({op_c, type_c, cnt_in_c});
  assign legal_c  = is_legal_xfer({op_c, type_c});
  assign accept_c = (state_q == IDLE) && bus.grant && legal_c && known_c
                    && (cnt_in_c != '0);

  dma_region_decode #(
    .ADDR_W   (ADDR_W),
    .IO1_BASE (IO1_BASE),
    .IO2_BASE (IO2_BASE)
  ) u_dst_decode (
    .addr  (dst_q),
    .hot_c (dst_hot_c)
  );

`ifdef DMA_REGION_CHECK_EN
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  src_inc_c;
  logic [ADDR_W-1:0]  dst_inc_c;
  strobe_t            ss_hot_c, sd_hot_c, src_hot_c, src_inc_hot_c, dst_inc_hot_c;

  assign src_inc_c = src_q + ADDR_W'(1);
  assign dst_inc_c = dst_q + ADDR_W'(1);

  dma_region_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_ss_decode  (.addr(bus.start_source),      .hot_c(ss_hot_c));
  dma_region_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_sd_decode  (.addr(bus.start_destination), .hot_c(sd_hot_c));
  dma_region_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_src_decode (.addr(src_q),                 .hot_c(src_hot_c));
  dma_region_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_sinc_decode(.addr(src_inc_c),             .hot_c(src_inc_hot_c));
  dma_region_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_dinc_decode(.addr(dst_inc_c),             .hot_c(dst_inc_hot_c));

  // Source/destination regions must agree with the requested direction
  always_comb begin
    acc_region_ok_c = 1'b0;
    case ({op_c, type_c})
      OP_IO2MEM:  acc_region_ok_c = !ss_hot_c.mem &&  sd_hot_c.mem;
      OP_MEM2IO:  acc_region_ok_c =  ss_hot_c.mem && !sd_hot_c.mem;
      OP_MEM2MEM: acc_region_ok_c =  ss_hot_c.mem &&  sd_hot_c.mem;
      default:    acc_region_ok_c = 1'b0;
    endcase
  end

  assign step_ok_c = (src_inc_hot_c == src_hot_c) && (dst_inc_hot_c == dst_hot_c);
  assign bus.dma_error = err_q;
`else
  assign acc_region_ok_c = 1'b1;
  assign step_ok_c       = 1'b1;
  assign bus.dma_error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    hold_d  = hold_q;
    drive_d = 1'b0;
    busy_d  = busy_q;
    addr_d  = addr_q;
    strb_d  = '0;
    ucnt_d  = ucnt_q;
    nsrc_d  = nsrc_q;
    ndst_d  = ndst_q;
    done_d  = 1'b0;
`ifdef DMA_REGION_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept_c) begin
          cnt_d = cnt_in_c;
          src_d = bus.start_source;
          dst_d = bus.start_destination;
`ifdef DMA_REGION_CHECK_EN
          err_d = !acc_region_ok_c;
`endif
          if (acc_region_ok_c) begin
            state_d = READ;
            busy_d  = 1'b1;
            addr_d  = bus.start_source;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        hold_d  = databus;
        state_d = WRITE;
        addr_d  = dst_q;
        drive_d = 1'b1;
        strb_d  = dst_hot_c;
      end
      WRITE: begin
        cnt_d  = cnt_q - CNT_W'(1);
        src_d  = src_q + ADDR_W'(1);
        dst_d  = dst_q + ADDR_W'(1);
        ucnt_d = cnt_d;
        nsrc_d = src_d;
        ndst_d = dst_d;
        if (cnt_d == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!step_ok_c) begin
          // Next word would cross a region boundary: stop before its strobe
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef DMA_REGION_CHECK_EN
          err_d   = 1'b1;
`endif
        end else begin
          state_d = READ;
          addr_d  = src_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      hold_q  <= '0;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      ucnt_q  <= '0;
      nsrc_q  <= '0;
      ndst_q  <= '0;
      done_q  <= 1'b0;
`ifdef DMA_REGION_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      hold_q  <= hold_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      ucnt_q  <= ucnt_d;
      nsrc_q  <= nsrc_d;
      ndst_q  <= ndst_d;
      done_q  <= done_d;
`ifdef DMA_REGION_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign databus              = drive_q ? hold_q : 'z;
  assign bus.busybus          = busy_q;
  assign bus.D_address        = addr_q;
  assign bus.D_memwrite       = strb_q.mem;
  assign bus.D_IOWrite1       = strb_q.io1;
  assign bus.D_IOWrite2       = strb_q.io2;
  assign bus.updated_count    = ucnt_q;
  assign bus.next_source      = nsrc_q;
  assign bus.next_destination = ndst_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_dma_transfer_engine.sv
// Bench for dma_transfer_engine: table of jobs, randomized jobs against a
// word-level transfer model, plus re-grant and mid-transfer reset sequences.
module tb_dma_transfer_engine;
  import dma_pkg::*;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [1:0] typ;
    int         cnt;
    logic [7:0] src;
    logic [7:0] dst;
    bit         exp_acc;
  } vec_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  wire  [31:0] databus;
  logic        tb_drv;

  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  exp_addr [64];
  logic [31:0] exp_data [64];
  logic [2:0]  exp_strb [64];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  m_ucnt   = '0;
  logic [7:0]  m_nsrc   = '0;
  logic [7:0]  m_ndst   = '0;
  bit          m_err    = 1'b0;

  vec_t        vecs [11];

  always #5 clock = ~clock;

  dma_transfer_engine_if bus_if ();

  dma_transfer_engine dut (
    .clock   (clock),
    .reset_n (reset_n),
    .databus (databus),
    .bus     (bus_if)
  );

  // Bus-side memory/IO device answers reads whenever the DMA owns the bus without a strobe
  assign tb_drv  = bus_if.busybus && !(bus_if.D_memwrite || bus_if.D_IOWrite1 || bus_if.D_IOWrite2);
  assign databus = tb_drv ? dev_mem[bus_if.D_address] : 'z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int region_of(input logic [7:0] a);
    if (a < 8'd192) return 0;
    if (a < 8'd224) return 1;
    return 2;
  endfunction

  function automatic bit legal_pair(input logic [1:0] op, input logic [1:0] typ);
    return (op == 2'b00 && typ == 2'b01) || (op == 2'b01 && typ == 2'b01) ||
           (op == 2'b01 && typ == 2'b10);
  endfunction

  function automatic bit region_pair_ok(input logic [1:0] op, input logic [1:0] typ,
                                        input logic [7:0] src, input logic [7:0] dst);
    if (op == 2'b00) return region_of(src) != 0 && region_of(dst) == 0;
    if (typ == 2'b01) return region_of(src) == 0 && region_of(dst) != 0;
    return region_of(src) == 0 && region_of(dst) == 0;
  endfunction

  // Word-level model: which words get written, where, with what data and strobe
  task automatic model_job(input logic [1:0] op, input logic [1:0] typ, input int cnt,
                           input logic [7:0] src, input logic [7:0] dst,
                           output bit acc, output int nw, output bit err);
    logic [7:0] s;
    logic [7:0] d;
    acc = legal_pair(op, typ) && cnt != 0;
    nw  = acc ? cnt : 0;
    err = 1'b0;
`ifdef DMA_REGION_CHECK_EN
    if (acc && !region_pair_ok(op, typ, src, dst)) begin
      nw  = 0;
      err = 1'b1;
    end else if (acc) begin
      for (int i = 0; i < cnt - 1; i++) begin
        s = src + 8'(i);
        d = dst + 8'(i);
        if (region_of(8'(s + 8'd1)) != region_of(s) || region_of(8'(d + 8'd1)) != region_of(d)) begin
          nw  = i + 1;
          err = 1'b1;
          break;
        end
      end
    end
`endif
    for (int i = 0; i < nw; i++) begin
      s = src + 8'(i);
      d = dst + 8'(i);
      exp_addr[i] = d;
      exp_data[i] = ref_mem[s];
      ref_mem[d]  = exp_data[i];
      case (region_of(d))
        0:       exp_strb[i] = 3'b100;
        1:       exp_strb[i] = 3'b010;
        default: exp_strb[i] = 3'b001;
      endcase
    end
  endtask

  task automatic check_status(input string name);
    check({name, " updated_count"},    64'(bus_if.updated_count),    64'(m_ucnt));
    check({name, " next_source"},      64'(bus_if.next_source),      64'(m_nsrc));
    check({name, " next_destination"}, 64'(bus_if.next_destination), 64'(m_ndst));
    check({name, " dma_error"},        64'(bus_if.dma_error),        64'(m_err));
  endtask

  task automatic run_job(input string name, input logic [1:0] op, input logic [1:0] typ,
                         input int cnt, input logic [7:0] src, input logic [7:0] dst,
                         input bit exp_acc, input int regrant_at);
    bit         acc;
    bit         err;
    bit         pend;
    int         nw;
    int         w;
    int         busy_n;
    int         done_n;
    int         done_cyc;
    logic [2:0] stb;
    model_job(op, typ, cnt, src, dst, acc, nw, err);
    @(negedge clock);
    bus_if.grant             = 1'b1;
    bus_if.DMA_instruction   = {op, typ, 16'h0, 6'(cnt)};
    bus_if.start_source      = src;
    bus_if.start_destination = dst;
    w = 0; busy_n = 0; done_n = 0; done_cyc = 0; pend = 1'b0;
    for (int c = 1; c <= 2 * cnt + 6; c++) begin
      @(negedge clock);
      if (pend) check({name, " count step"}, 64'(bus_if.updated_count), 64'(cnt - w));
      pend = 1'b0;
      stb  = {bus_if.D_memwrite, bus_if.D_IOWrite1, bus_if.D_IOWrite2};
      if (bus_if.busybus) busy_n++;
      if (stb != 3'b000) begin
        if (w < nw) begin
          check($sformatf("%s wr%0d addr", name, w),   64'(bus_if.D_address), 64'(exp_addr[w]));
          check($sformatf("%s wr%0d data", name, w),   64'(databus),          64'(exp_data[w]));
          check($sformatf("%s wr%0d strobe", name, w), 64'(stb),              64'(exp_strb[w]));
        end else begin
          check({name, " extra write"}, 64'(w + 1), 64'(nw));
        end
        dev_mem[bus_if.D_address] = databus;
        w++;
        pend = 1'b1;
      end
      if (bus_if.done) begin
        done_n++;
        if (done_n == 1) done_cyc = c;
      end
      if (c == 1 || bus_if.done) begin
        bus_if.grant           = 1'b0;
        bus_if.DMA_instruction = '0;
      end else if (c == regrant_at) begin
        bus_if.grant             = 1'b1;
        bus_if.DMA_instruction   = {2'b01, 2'b10, 16'h0, 6'd5};
        bus_if.start_source      = 8'd0;
        bus_if.start_destination = 8'd0;
      end
    end
    bus_if.grant           = 1'b0;
    bus_if.DMA_instruction = '0;
    check({name, " writes"},      64'(w),        64'(nw));
    check({name, " busy cycles"}, 64'(busy_n),   64'(2 * nw));
    check({name, " done pulses"}, 64'(done_n),   64'(exp_acc ? 1 : 0));
    check({name, " done cycle"},  64'(done_cyc), 64'(exp_acc ? 2 * nw + 1 : 0));
    if (acc) begin
      m_err = err;
      if (nw > 0) begin
        m_ucnt = 6'(cnt - nw);
        m_nsrc = 8'(src + 8'(nw));
        m_ndst = 8'(dst + 8'(nw));
      end
    end
    check_status(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " busybus"},  64'(bus_if.busybus),   64'(0));
    check({name, " D_address"}, 64'(bus_if.D_address), 64'(0));
    check({name, " strobes"},  64'({bus_if.D_memwrite, bus_if.D_IOWrite1, bus_if.D_IOWrite2}), 64'(0));
    check({name, " done"},     64'(bus_if.done),      64'(0));
    check_status(name);
  endtask

  initial begin
    bus_if.grant             = 1'b0;
    bus_if.DMA_instruction   = '0;
    bus_if.start_source      = '0;
    bus_if.start_destination = '0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end

    vecs[0]  = '{"mem2mem 3",    2'b01, 2'b10,  3, 8'd10,  8'd100, 1'b1};
    vecs[1]  = '{"mem2io2 2",    2'b01, 2'b01,  2, 8'd5,   8'd224, 1'b1};
    vecs[2]  = '{"io2mem wrap",  2'b00, 2'b01,  2, 8'd255, 8'd0,   1'b1};
    vecs[3]  = '{"op10 ignored", 2'b10, 2'b01,  3, 8'd10,  8'd20,  1'b0};
    vecs[4]  = '{"count0",       2'b01, 2'b10,  0, 8'd10,  8'd20,  1'b0};
    vecs[5]  = '{"op11 ty11",    2'b11, 2'b11,  4, 8'd1,   8'd2,   1'b0};
    vecs[6]  = '{"op00 ty10",    2'b00, 2'b10,  4, 8'd200, 8'd2,   1'b0};
    vecs[7]  = '{"max 63",       2'b01, 2'b10, 63, 8'd20,  8'd120, 1'b1};
    vecs[8]  = '{"mem2io1 4",    2'b01, 2'b01,  4, 8'd50,  8'd192, 1'b1};
    vecs[9]  = '{"io1mem 5",     2'b00, 2'b01,  5, 8'd200, 8'd30,  1'b1};
    vecs[10] = '{"mem2mem to io", 2'b01, 2'b10, 2, 8'd10,  8'd200, 1'b1};

    #2 reset_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      run_job(vecs[k].name, vecs[k].op, vecs[k].typ, vecs[k].cnt,
              vecs[k].src, vecs[k].dst, vecs[k].exp_acc, 0);
    end

    for (int k = 0; k < 24; k++) begin
      logic [1:0] op;
      logic [1:0] typ;
      logic [7:0] src;
      logic [7:0] dst;
      int         cnt;
      int         pick;
      pick = int'($urandom_range(0, 9));
      cnt  = int'($urandom_range(1, 20));
      src  = 8'($urandom);
      dst  = 8'($urandom);
      if (pick <= 2) begin
        op = 2'b00; typ = 2'b01;
        src = 8'($urandom_range(192, 255)); dst = 8'($urandom_range(0, 191));
      end else if (pick <= 5) begin
        op = 2'b01; typ = 2'b01;
        src = 8'($urandom_range(0, 191)); dst = 8'($urandom_range(192, 255));
      end else if (pick <= 7) begin
        op = 2'b01; typ = 2'b10;
        src = 8'($urandom_range(0, 191)); dst = 8'($urandom_range(0, 191));
      end else if (pick == 8) begin
        op = 2'($urandom); typ = 2'($urandom);
      end else begin
        op = 2'b01; typ = 2'b10; cnt = 0;
      end
      run_job($sformatf("rand%0d", k), op, typ, cnt, src, dst,
              legal_pair(op, typ) && cnt != 0, 0);
    end

    // A second grant with a fresh instruction arrives while a job is running
    run_job("regrant", 2'b01, 2'b10, 6, 8'd30, 8'd90, 1'b1, 3);

    // Reset in cycle 5 of a 4-word job: two words already written, then abort
    begin
      int w;
      int done_n;
      @(negedge clock);
      bus_if.grant             = 1'b1;
      bus_if.DMA_instruction   = {2'b01, 2'b10, 16'h0, 6'd4};
      bus_if.start_source      = 8'd40;
      bus_if.start_destination = 8'd60;
      w = 0;
      done_n = 0;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clock);
        if (bus_if.D_memwrite || bus_if.D_IOWrite1 || bus_if.D_IOWrite2) begin
          dev_mem[bus_if.D_address] = databus;
          w++;
        end
        if (bus_if.done) done_n++;
        if (c == 1) begin
          bus_if.grant           = 1'b0;
          bus_if.DMA_instruction = '0;
        end
      end
      check("rst-mid writes before reset", 64'(w), 64'(2));
      ref_mem[60] = ref_mem[40];
      ref_mem[61] = ref_mem[41];
      reset_n = 1'b0;
      #1;
      m_ucnt = '0; m_nsrc = '0; m_ndst = '0; m_err = 1'b0;
      check_reset_outputs("rst-mid");
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clock);
        if (bus_if.done) done_n++;
        if (bus_if.busybus) done_n++;
      end
      check("rst-mid no done/busy after", 64'(done_n), 64'(0));
    end

    run_job("post reset", 2'b01, 2'b01, 3, 8'd100, 8'd200, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_transfer_engine.md
Name: dma_transfer_engine

Overview:
- Responder end of the processor→DMA handoff. Accepts a multi-word transfer instruction, presented with grant, and takes ownership of the shared bus.
- Moves count words between memory (0–191), I/O1 (192–223) and I/O2 (224–255), one read phase plus one write phase per word.
- Reports busybus, remaining count and current source/destination pointers back to the processor and register file.

Parameters:
DATA_W, 32, databus width
ADDR_W, 8, address width
CNT_W, 6, word-count field width (instruction[5:0])
IO1_BASE, 192, first I/O1 address
IO2_BASE, 224, first I/O2 address

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
grant  in  1  processor hands the bus to the DMA
DMA_instruction  in  26  [25:24] op, [23:22] type, [5:0] count; high-Z when not presented
start_source  in  ADDR_W  source base address, sampled at accept
start_destination  in  ADDR_W  destination base address, sampled at accept
databus  inout  DATA_W  shared data bus; driven only in WRITE state
busybus  out  1  DMA owns the bus
D_address  out  ADDR_W  bus address
D_IOWrite1  out  1  write strobe to I/O1
D_IOWrite2  out  1  write strobe to I/O2
D_memwrite  out  1  write strobe to memory
updated_count  out  CNT_W  words remaining
next_source  out  ADDR_W  current source pointer
next_destination  out  ADDR_W  current destination pointer
done  out  1  one-cycle completion pulse
dma_error  out  1  sticky error flag (only with the optional feature)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state IDLE; busybus, all strobes, done, dma_error = 0.
  - D_address = 0; updated_count = 0; next_source = next_destination = 0.
  - databus released (Z); hold register = 0.
- Legal (op,type) pairs: (00,01) I/O→mem; (01,01) mem→I/O; (01,10) mem→mem. All others are ignored and cause no state change.
- Accept: in IDLE, on a rising edge with grant=1, legal op/type, count≠0 and no X/Z on op/type/count:
  - latch instruction, count, start_source, start_destination.
  - go to READ; busybus=1 from the next cycle onward.
- READ (1 cycle): D_address = source pointer; all strobes 0; databus Z. At the end of the cycle, latch databus into the hold register.
- WRITE (1 cycle):
  - D_address = destination pointer; databus driven from the hold register.
  - Strobe by destination region: 0–191 → D_memwrite; 192–223 → D_IOWrite1; 224–255 → D_IOWrite2. Exactly one strobe is high.
  - At the end of the cycle: count−1, source+1, destination+1 (ADDR_W modulo; 255 wraps to 0).
  - Next state is READ if the new count≠0, otherwise DONE.
- DONE (1 cycle): done=1, busybus=0, strobes 0, databus Z; return to IDLE.
- Timing:
  - Throughput is 2 cycles per word. Total busybus-high cycles = 2·count.
  - done asserts on cycle 2·count+1 after accept.
  - count=63 takes 126 busy cycles.
- grant deasserting mid-transfer is ignored; the transfer runs to completion. grant and instructions arriving in READ/WRITE/DONE are ignored, with no queueing.
- updated_count, next_source and next_destination update only on WRITE→next transitions and hold their values in IDLE.
- Reset asserted mid-transfer aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro: DMA_REGION_CHECK_EN.
- Defined:
  - At accept, the engine checks that the source region and destination region match the op/type (I/O→mem: source ≥192, destination <192; mem→I/O: source <192, destination ≥192; mem→mem: both <192).
  - Before each WRITE, the engine checks that incrementing stays within the same region.
  - On violation: no further strobes are issued; go to DONE with done=1; dma_error is set and stays set until reset or the next accept.
- Undefined: no checks are made; dma_error is tied to 0; pointers wrap freely.

Decomposition:
- Shared package dma_pkg holds:
  - op/type encodings (OP_IO2MEM, OP_MEM2IO, OP_MEM2MEM).
  - region boundary constants.
  - instruction field bit positions.
  - state enum (IDLE, READ, WRITE, DONE).
- One sub-module, dma_region_decode: combinational address → {mem, io1, io2} decode. It is used for strobe selection and for the optional check.

Test Plan:
- Reset mid-transfer:
  - Stimulus: reset_n=0 at cycle 5 of a count=4 job.
  - Expected: all outputs return to reset values asynchronously; no done pulse.
- mem→mem, count=3, start_source=10, start_destination=100, memory[10..12]=A,B,C:
  - Expected: busybus high for 6 cycles.
  - D_memwrite pulses at addresses 100, 101, 102 with data A, B, C.
  - updated_count steps 2, 1, 0; done pulses once.
- mem→I/O2, count=2, source=5, destination=224:
  - Expected: D_IOWrite2 pulses at 224 and 225; D_memwrite and D_IOWrite1 stay 0.
- I/O→mem at the wrap boundary, count=2, start_source=255, destination=0:
  - Without the macro: source pointer wraps to 0; writes to 0 and 1.
  - With DMA_REGION_CHECK_EN: error raised and at most one write.
- Ignored requests:
  - grant=1 with op=10: no accept, busybus stays 0.
  - grant=1 with count=0: no accept.
  - A second grant during an active job: no effect on the running transfer.
- Maximum job, count=63:
  - Expected: exactly 63 write strobes; busybus high for exactly 126 cycles; next_destination = start+63 (mod 256).
